// File: rtl/bsg_fpu_normalize_pipe_pkg.sv
// Shared FPU definitions: shift-width helper and the zero/denorm flag encoding
// shared by the normalize and rounding stages.
package bsg_fpu_normalize_pipe_pkg;

  function automatic int unsigned lg_width_f(input int unsigned width);
    return $clog2(width);
  endfunction

  typedef struct packed {
    logic zero;
    logic denorm;
  } fpu_flags_s;

  localparam fpu_flags_s fpu_flags_none_lp   = '{zero: 1'b0, denorm: 1'b0};
  localparam fpu_flags_s fpu_flags_zero_lp   = '{zero: 1'b1, denorm: 1'b0};
  localparam fpu_flags_s fpu_flags_denorm_lp = '{zero: 1'b0, denorm: 1'b1};

endpackage

// File: rtl/bsg_fpu_clz.sv
// Leading-zero counter, MSB first; returns 0 for an all-zero input.
module bsg_fpu_clz
  import bsg_fpu_normalize_pipe_pkg::*;
#(
  parameter int unsigned width_p = 16
) (
  input  logic [width_p-1:0]             a_i,
  output logic [lg_width_f(width_p)-1:0] num_zero_o
);

  localparam int unsigned lg_width_lp = lg_width_f(width_p);

  // Highest set bit wins since it is visited last.
  always_comb begin
    num_zero_o = '0;
    for (int i = 0; i < width_p; i++) begin
      if (a_i[i]) num_zero_o = lg_width_lp'(width_p - 1 - i);
    end
  end

endmodule

// File: rtl/bsg_fpu_normalize_pipe.sv
// Two-stage mantissa normalizer: stage 1 captures operands and leading-zero
// count, stage 2 shifts and adjusts the exponent without underflowing it.
module bsg_fpu_normalize_pipe
  import bsg_fpu_normalize_pipe_pkg::*;
#(
  parameter int unsigned width_p     = 16,
  parameter int unsigned exp_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     mant_i,
  input  logic [exp_width_p-1:0] exp_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_p-1:0]     mant_o,
  output logic [exp_width_p-1:0] exp_o,
  output logic                   zero_o,
  output logic                   denorm_o,
  input  logic                   yumi_i
);

  localparam int unsigned lg_width_lp  = lg_width_f(width_p);
  localparam int unsigned cmp_width_lp = (exp_width_p > lg_width_lp) ? exp_width_p : lg_width_lp;

  typedef struct packed {
    logic [width_p-1:0]     mant;
    logic [exp_width_p-1:0] exp;
    logic                   zero;
    logic [lg_width_lp-1:0] shamt;
  } stage1_s;

  logic                   v1_q, v1_d, v2_q, v2_d;
  stage1_s                s1_q, s1_d;
  logic [width_p-1:0]     mant_q, mant_d;
  logic [exp_width_p-1:0] exp_q, exp_d;
  fpu_flags_s             flags_q, flags_d;
  logic [lg_width_lp-1:0] clz_count;
  logic [cmp_width_lp-1:0] exp_ext, shamt_ext;
  logic                   adv2, accept;

  bsg_fpu_clz #(.width_p(width_p)) clz (
    .a_i        (mant_i),
    .num_zero_o (clz_count)
  );

  assign adv2    = v1_q & (~v2_q | yumi_i);
  assign ready_o = ~reset_i & (~v1_q | adv2);
  assign accept  = v_i & ready_o;

  assign exp_ext   = cmp_width_lp'(s1_q.exp);
  assign shamt_ext = cmp_width_lp'(s1_q.shamt);

  always_comb begin
    v1_d    = accept | (v1_q & ~adv2);
    v2_d    = adv2 | (v2_q & ~yumi_i);
    s1_d    = s1_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    flags_d = flags_q;

    if (accept) begin
      s1_d.mant  = mant_i;
      s1_d.exp   = exp_i;
      s1_d.zero  = (mant_i == '0);
      s1_d.shamt = clz_count;
    end

    // Shift is capped by the exponent so the result never underflows.
    if (adv2) begin
      if (s1_q.zero) begin
        mant_d  = '0;
        exp_d   = '0;
        flags_d = fpu_flags_zero_lp;
      end else if (exp_ext >= shamt_ext) begin
        mant_d  = s1_q.mant << s1_q.shamt;
        exp_d   = exp_width_p'(exp_ext - shamt_ext);
        flags_d = fpu_flags_none_lp;
      end else begin
        mant_d  = s1_q.mant << exp_ext;
        exp_d   = '0;
        flags_d = fpu_flags_denorm_lp;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      s1_q    <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
      flags_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      s1_q    <= s1_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      flags_q <= flags_d;
    end
  end

  assign v_o      = v2_q;
  assign mant_o   = mant_q;
  assign exp_o    = exp_q;
  assign zero_o   = flags_q.zero;
  assign denorm_o = flags_q.denorm;

endmodule

// File: tb/tb_bsg_fpu_normalize_pipe.sv
// Self-checking bench for bsg_fpu_normalize_pipe: directed cases, backpressure,
// random streaming against a shift-loop reference model, and mid-flight reset.
module tb_bsg_fpu_normalize_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned E = 8;
  localparam int unsigned R = W + E + 2;

  logic         clk = 1'b0;
  logic         reset_i, v_i, yumi_i;
  logic [W-1:0] mant_i;
  logic [E-1:0] exp_i;
  logic         ready_o, v_o, zero_o, denorm_o;
  logic [W-1:0] mant_o;
  logic [E-1:0] exp_o;

  int errors = 0;
  int checks = 0;
  logic [R-1:0] exp_q[$];

  bsg_fpu_normalize_pipe #(.width_p(W), .exp_width_p(E)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .mant_i   (mant_i),
    .exp_i    (exp_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .mant_o   (mant_o),
    .exp_o    (exp_o),
    .zero_o   (zero_o),
    .denorm_o (denorm_o),
    .yumi_i   (yumi_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_i) assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o low");
  end

  // Normalize one bit at a time while the exponent still has room.
  function automatic logic [R-1:0] ref_norm(input logic [W-1:0] m, input logic [E-1:0] e);
    logic [W-1:0] mm;
    int           ee;
    if (m == '0) return {W'(0), E'(0), 1'b1, 1'b0};
    mm = m;
    ee = int'(e);
    while (!mm[W-1] && ee > 0) begin
      mm = mm << 1;
      ee--;
    end
    return {mm, E'(ee), 1'b0, ~mm[W-1]};
  endfunction

  function automatic logic [R-1:0] observed();
    return {mant_o, exp_o, zero_o, denorm_o};
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; mant_i = '0; exp_i = '0;
    @(negedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_low got=%b exp=0", ready_o); end
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
    checks++;
    if (observed() !== R'(0)) begin errors++; $display("FAIL reset_data got=%h exp=0", observed()); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_directed();
    logic [W-1:0] tm[7]  = '{16'h0100, 16'h0001, 16'h0000, 16'h8000, 16'h0004, 16'h0001, 16'h0003};
    logic [E-1:0] te[7]  = '{8'd20,    8'd5,     8'd100,   8'd0,     8'd13,    8'd0,     8'd255};
    logic [W-1:0] em[7]  = '{16'h8000, 16'h0020, 16'h0000, 16'h8000, 16'h8000, 16'h0001, 16'hC000};
    logic [E-1:0] ee[7]  = '{8'd13,    8'd0,     8'd0,     8'd0,     8'd0,     8'd0,     8'd241};
    logic         ez[7]  = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};
    logic         ed[7]  = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
    logic [R-1:0] want;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mant_i = tm[i]; exp_i = te[i]; v_i = 1'b1; yumi_i = 1'b0;
      #1;
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL dir%0d_ready got=%b exp=1", i, ready_o); end
      @(negedge clk);
      v_i = 1'b0;
      checks++;
      if (v_o !== 1'b0) begin errors++; $display("FAIL dir%0d_early_v got=%b exp=0", i, v_o); end
      @(negedge clk);
      want = {em[i], ee[i], ez[i], ed[i]};
      checks++;
      if (v_o !== 1'b1) begin errors++; $display("FAIL dir%0d_v got=%b exp=1", i, v_o); end
      checks++;
      if (observed() !== want) begin errors++; $display("FAIL dir%0d_data got=%h exp=%h", i, observed(), want); end
      yumi_i = v_o;
      @(negedge clk);
      yumi_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] bm[3] = '{16'h0100, 16'h0030, 16'h1234};
    logic [E-1:0] be[3] = '{8'd20, 8'd3, 8'd60};
    logic [R-1:0] r0, r1, r2;
    r0 = ref_norm(bm[0], be[0]);
    r1 = ref_norm(bm[1], be[1]);
    r2 = ref_norm(bm[2], be[2]);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      yumi_i = 1'b0; v_i = 1'b1; mant_i = bm[i]; exp_i = be[i];
      #1;
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got=%b exp=1", i, ready_o); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mant_i = bm[2]; exp_i = be[2]; v_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready%0d got=%b exp=0", c, ready_o); end
      checks++;
      if (v_o !== 1'b1 || observed() !== r0) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", c, v_o, observed(), r0);
      end
    end
    @(negedge clk);
    yumi_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_refill_ready got=%b exp=1", ready_o); end
    checks++;
    if (observed() !== r0) begin errors++; $display("FAIL bp_out0 got=%h exp=%h", observed(), r0); end
    @(negedge clk);
    v_i = 1'b0;
    checks++;
    if (v_o !== 1'b1 || observed() !== r1) begin errors++; $display("FAIL bp_out1 got=%b/%h exp=1/%h", v_o, observed(), r1); end
    @(negedge clk);
    checks++;
    if (v_o !== 1'b1 || observed() !== r2) begin errors++; $display("FAIL bp_out2 got=%b/%h exp=1/%h", v_o, observed(), r2); end
    @(negedge clk);
    yumi_i = 1'b0;
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", v_o); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [R-1:0] want;
    exp_q.delete();
    while ((sent < 200 || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      yumi_i = v_o && ($urandom_range(0, 3) != 0);
      if (yumi_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra got=%h exp=none", observed());
        end else begin
          want = exp_q.pop_front();
          got++;
          if (observed() !== want) begin errors++; $display("FAIL stream_item%0d got=%h exp=%h", got, observed(), want); end
        end
      end
      v_i = (sent < 200) && ($urandom_range(0, 3) != 0);
      mant_i = ($urandom_range(0, 15) == 0) ? W'(0) : W'($urandom >> $urandom_range(16, 31));
      exp_i  = ($urandom_range(0, 1) != 0) ? E'($urandom_range(0, 16)) : E'($urandom);
      #1;
      if (v_i && ready_o) begin
        exp_q.push_back(ref_norm(mant_i, exp_i));
        sent++;
      end
    end
    @(negedge clk);
    v_i = 1'b0; yumi_i = 1'b0;
    checks++;
    if (got !== 200) begin errors++; $display("FAIL stream_count got=%0d exp=200 (cycles=%0d)", got, cyc); end
  endtask

  task automatic test_back_to_back();
    logic [R-1:0] want;
    exp_q.delete();
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if (v_o !== 1'b1) begin errors++; $display("FAIL b2b_v%0d got=%b exp=1", c, v_o); end
      end
      yumi_i = v_o;
      if (v_o && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checks++;
        if (observed() !== want) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", c, observed(), want); end
      end
      v_i = (c < 20);
      mant_i = W'($urandom >> $urandom_range(16, 31));
      exp_i  = E'($urandom_range(0, 20));
      #1;
      if (v_i) begin
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", c, ready_o); end
        if (ready_o) exp_q.push_back(ref_norm(mant_i, exp_i));
      end
    end
    @(negedge clk);
    v_i = 1'b0; yumi_i = 1'b0;
    checks++;
    if (exp_q.size() != 0 || v_o !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got=%0d/%b exp=0/0", exp_q.size(), v_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [R-1:0] want;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      yumi_i = 1'b0; v_i = 1'b1; mant_i = W'(16'h0F00 >> i); exp_i = E'(30);
    end
    @(negedge clk);
    v_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b1 || ready_o !== 1'b0) begin errors++; $display("FAIL rm_full got=%b/%b exp=1/0", v_o, ready_o); end
    reset_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset got=%b exp=0", ready_o); end
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0 || ready_o !== 1'b1 || observed() !== R'(0)) begin
      errors++; $display("FAIL rm_after got=%b/%b/%h exp=0/1/0", v_o, ready_o, observed());
    end
    @(negedge clk);
    v_i = 1'b1; mant_i = 16'h0002; exp_i = 8'd40;
    want = ref_norm(16'h0002, 8'd40);
    @(negedge clk);
    v_i = 1'b0;
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL rm_lat1 got=%b exp=0", v_o); end
    @(negedge clk);
    checks++;
    if (v_o !== 1'b1 || observed() !== want) begin errors++; $display("FAIL rm_lat2 got=%b/%h exp=1/%h", v_o, observed(), want); end
    yumi_i = v_o;
    @(negedge clk);
    yumi_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/bsg_fpu_normalize_pipe.md
Name: bsg_fpu_normalize_pipe

Overview:
- Two-stage pipelined mantissa normalizer. It sits directly downstream of the leading-zero counter, which it instantiates in stage 1 and consumes the count of.
- Takes an unnormalized mantissa and biased exponent from the FPU add/sub datapath.
- Left-shifts the mantissa so its MSB is 1, or as far as the exponent allows, and reduces the exponent by the shift amount.
- Valid/ready in, valid/yumi out; full throughput with backpressure.

Parameters:
- width_p, 16, mantissa width; power of 2, at least 4.
- exp_width_p, 8, biased exponent width (unsigned).
- lg_width_lp, $clog2(width_p), shift-amount width; localparam.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  input valid.
- mant_i  in  width_p  unnormalized mantissa.
- exp_i  in  exp_width_p  biased exponent.
- ready_o  out  1  block can accept input this cycle.
- v_o  out  1  output valid.
- mant_o  out  width_p  normalized mantissa.
- exp_o  out  exp_width_p  adjusted exponent.
- zero_o  out  1  input mantissa was all zeros.
- denorm_o  out  1  shift limited by exponent; result is subnormal.
- yumi_i  in  1  consumer takes output; legal only when v_o=1.

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- Reset values: all stage valid bits are 0 and all data registers are 0. Therefore v_o=0, mant_o=0, exp_o=0, zero_o=0, denorm_o=0 and ready_o=1 in the cycle after reset_i is seen high.
- Reset mid-operation: reset_i high discards all in-flight items; no output is produced for them. While reset_i=1, ready_o=0.
- Stage 1 (on accept, v_i & ready_o):
  - registers mant_i and exp_i;
  - registers zero = (mant_i==0);
  - registers shamt = leading-zero count of mant_i (MSB first), lg_width_lp bits, 0..width_p-1.
- Stage 2 (on advance from stage 1):
  - zero=1: mant_o=0, exp_o=0, zero_o=1, denorm_o=0. The count is ignored; the counter returns 0 for an all-zero input, so zero detection is separate.
  - else if exp >= shamt: mant_o = mant << shamt, exp_o = exp - shamt, denorm_o=0. exp==shamt gives exp_o=0 with a normalized mantissa and denorm_o=0.
  - else (exp < shamt): mant_o = mant << exp, exp_o=0, denorm_o=1.
  - The exponent subtract never wraps: the compare is unsigned at exp_width_p bits. shamt is zero-extended; if exp_width_p < lg_width_lp, exp is zero-extended for the compare instead.
- Latency: exactly 2 cycles from accept to v_o with no backpressure. Throughput is 1 item per cycle.
- Handshake and flow control:
  - Each stage holds a valid bit: v1 and v2, with v_o = v2.
  - adv2 = v1 & (~v2 | yumi_i).
  - ready_o = ~v1 | adv2, so stage 1 refills in the same cycle it drains.
  - Simultaneous yumi_i and new input with both stages full: stage 2 loads from stage 1, stage 1 loads the new input, and nothing is lost.
- Full: with v1=v2=1 and yumi_i=0, ready_o=0, and outputs hold stable until yumi_i.
- Empty: v_o=0; output data holds its last value and is don't-care to the consumer.
- Ordering: strictly in order; no reordering or dropping.
- Illegal stimulus: yumi_i=1 while v_o=0. The bench flags it with an assertion; the RTL takes no action.

Decomposition:
- Shared FPU package:
  - lg_width_lp computation helper;
  - a packed struct {mant, exp, zero, shamt} for the stage-1 register, parameterized by width_p and exp_width_p (or built as a localparam bundle);
  - a denorm/zero flag encoding constant, also used by the rounding stage.
- Sub-module: the existing leading-zero counter (bsg_fpu_clz, width_p) is instantiated in stage 1.
- Shifter and exponent adjust are inline in stage 2. No other sub-modules.

Test Plan:
- Normal case (width_p=16, exp_width_p=8): mant_i=0x0100, exp_i=20, yumi_i=1 held -> 2 cycles later v_o=1, mant_o=0x8000, exp_o=13, zero_o=0, denorm_o=0.
- Exponent-limited shift: mant_i=0x0001, exp_i=5 -> mant_o=0x0020, exp_o=0, denorm_o=1.
- Boundaries:
  - mant_i=0x0000, exp_i=100 -> mant_o=0, exp_o=0, zero_o=1.
  - mant_i=0x8000, exp_i=0 -> mant_o=0x8000, exp_o=0, denorm_o=0.
  - mant_i=0x0004, exp_i=13 (shamt=13) -> mant_o=0x8000, exp_o=0, denorm_o=0.
- Backpressure: yumi_i=0, offer 3 items back-to-back -> first 2 accepted, then ready_o=0 and v_o/data stable. Assert yumi_i for 3 cycles -> all 3 outputs in order; third accepted in the cycle yumi_i first rises.
- Streaming: 200 random items with random v_i/yumi_i -> scoreboard against a reference model, zero loss/duplication; with v_i=yumi_i=1 constant, throughput is 1/cycle.
- Reset mid-operation: reset_i=1 for 1 cycle with both stages full -> next cycle v_o=0, ready_o=1, outputs all 0; the first post-reset item has latency 2.
